// File: rtl/trace_frame_capture.sv
// trace_frame_capture: TPIU sync search, halfword assembly and frame FIFO.
// Optional macro SYNC_TIMEOUT_EN adds a sync timeout and ignoreSyncTimeout.
module trace_frame_capture #(
   parameter int MAXBUSWIDTH = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_BITS   = 27
) (
   input  logic                   traceClkin,
   input  logic                   rst,
   input  logic [MAXBUSWIDTH-1:0] traceDina,
   input  logic [MAXBUSWIDTH-1:0] traceDinb,
   input  logic [1:0]             width,
`ifdef SYNC_TIMEOUT_EN
   input  logic                   ignoreSyncTimeout,
`endif
   input  logic                   frameReady,
   output logic                   frameValid,
   output logic [127:0]           frameData,
   output logic                   synced,
   output logic [3:0]             syncOffset,
   output logic [15:0]            overflowCount
);

   localparam int SRW    = 32 + 2 * MAXBUSWIDTH;
   localparam int TOP    = SRW - 1;
   localparam int MAXLOG = $clog2(MAXBUSWIDTH);
   localparam int AW     = $clog2(DEPTH);
   localparam logic [AW:0] PONE = (AW + 1)'(1);

   logic [1:0]               wEff;
   logic [3:0]               laneBits;
   logic [4:0]               chunkBits;
   logic [2:0]               cReload;
   logic [MAXBUSWIDTH-1:0]   laneMask;
   logic [2*MAXBUSWIDTH-1:0] chunk;
   logic [SRW-1:0]           sr_q, sr_d;

   logic [1:0]   width_q;
   logic         widthChg;
   logic         found;
   logic [3:0]   foundOff;
   logic [15:0]  hw;
   logic         timeout;

   logic         synced_q, synced_d;
   logic [3:0]   off_q, off_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [2:0]   slot_q, slot_d;
   logic [127:0] frame_q, frame_d;
   logic         push;

   logic [127:0] mem_q [DEPTH];
   logic [AW:0]  wp_q, wp_d;
   logic [AW:0]  rp_q, rp_d;
   logic [15:0]  ovf_q, ovf_d;
   logic         empty, full, pop, wr, drop;

   assign wEff      = (int'(width) > MAXLOG) ? 2'(MAXLOG) : width;
   assign laneBits  = 4'd1 << wEff;
   assign chunkBits = 5'd2 << wEff;
   assign cReload   = 3'((4'd8 >> wEff) - 4'd1);
   assign widthChg  = (width != width_q);
   assign hw        = sr_q[TOP - int'(off_q) -: 16];

   // Gather the active lanes of both edges, rising-edge bits in the low half.
   always_comb begin
      laneMask = MAXBUSWIDTH'((32'd1 << laneBits) - 32'd1);
      chunk = {{MAXBUSWIDTH{1'b0}}, traceDina & laneMask}
            | ({{MAXBUSWIDTH{1'b0}}, traceDinb & laneMask} << laneBits);
      sr_d = (sr_q >> chunkBits)
           | ({chunk, 32'h0} << (5'(2 * MAXBUSWIDTH) - chunkBits));
   end

   // Search every bit offset of the newest chunk; the lowest hit wins.
   always_comb begin
      found    = 1'b0;
      foundOff = '0;
      for (int o = 0; o < 2 * MAXBUSWIDTH; o++) begin
         if (!found && (5'(o) < chunkBits) &&
             (sr_q[TOP - o -: 32] == 32'h7FFF_FFFF)) begin
            found    = 1'b1;
            foundOff = 4'(o);
         end
      end
   end

`ifdef SYNC_TIMEOUT_EN
   logic [SYNC_BITS-1:0] to_q, to_d;

   assign timeout = synced_q && (to_q == '0) && !ignoreSyncTimeout;

   // Timeout counter restarts on each sync and runs down to zero.
   always_comb begin
      to_d = to_q;
      if (found && !widthChg)
         to_d = '1;
      else if (to_q != '0)
         to_d = to_q - SYNC_BITS'(1);
   end

   // Timeout counter register.
   always_ff @(posedge traceClkin or posedge rst) begin
      if (rst)
         to_q <= '0;
      else
         to_q <= to_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Alignment and halfword assembly; sync beats a completing halfword.
   always_comb begin
      synced_d = synced_q;
      off_d    = off_q;
      cnt_d    = cnt_q;
      slot_d   = slot_q;
      frame_d  = frame_q;
      push     = 1'b0;
      if (widthChg) begin
         synced_d = 1'b0;
         slot_d   = '0;
      end else if (found) begin
         synced_d = 1'b1;
         off_d    = foundOff;
         cnt_d    = cReload;
         slot_d   = '0;
      end else if (timeout) begin
         synced_d = 1'b0;
         slot_d   = '0;
      end else if (synced_q) begin
         if (cnt_q == '0) begin
            cnt_d = cReload;
            if (hw != 16'h7FFF) begin
               frame_d[127 - 16 * int'(slot_q) -: 16] = {hw[7:0], hw[15:8]};
               slot_d = slot_q + 3'd1;
               push   = (slot_q == 3'd7);
            end
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
      end
   end

   // FIFO pointer and overflow bookkeeping; a full FIFO with a pop still
   // takes the new frame.
   always_comb begin
      empty = (wp_q == rp_q);
      full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
      pop   = !empty && frameReady;
      wr    = push && (!full || pop);
      drop  = push && full && !pop;
      wp_d  = wr ? wp_q + PONE : wp_q;
      rp_d  = pop ? rp_q + PONE : rp_q;
      ovf_d = (drop && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
   end

   // Capture state, with asynchronous clear of everything that can sync.
   always_ff @(posedge traceClkin or posedge rst) begin
      if (rst) begin
         sr_q     <= '0;
         width_q  <= '0;
         synced_q <= 1'b0;
         off_q    <= '0;
         cnt_q    <= '0;
         slot_q   <= '0;
         frame_q  <= '0;
         wp_q     <= '0;
         rp_q     <= '0;
         ovf_q    <= '0;
      end else begin
         sr_q     <= sr_d;
         width_q  <= width;
         synced_q <= synced_d;
         off_q    <= off_d;
         cnt_q    <= cnt_d;
         slot_q   <= slot_d;
         frame_q  <= frame_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         ovf_q    <= ovf_d;
      end
   end

   // Frame storage; contents are masked at the output while empty.
   always_ff @(posedge traceClkin) begin
      if (wr)
         mem_q[wp_q[AW-1:0]] <= frame_d;
   end

   assign frameValid    = !empty;
   assign frameData     = empty ? '0 : mem_q[rp_q[AW-1:0]];
   assign synced        = synced_q;
   assign syncOffset    = off_q;
   assign overflowCount = ovf_q;

endmodule

// File: tb/tb_trace_frame_capture.sv
// tb_trace_frame_capture: directed table, corner sequences and random
// stream against a bit-stream reference model.
module tb_trace_frame_capture;

   localparam int MAXB  = 8;
   localparam int DEPTH = 4;
`ifdef SYNC_TIMEOUT_EN
   localparam int SB = 4;
`else
   localparam int SB = 27;
`endif

   logic            traceClkin;
   logic            rst;
   logic [MAXB-1:0] traceDina;
   logic [MAXB-1:0] traceDinb;
   logic [1:0]      width;
   logic            frameReady;
   logic            frameValid;
   logic [127:0]    frameData;
   logic            synced;
   logic [3:0]      syncOffset;
   logic [15:0]     overflowCount;
`ifdef SYNC_TIMEOUT_EN
   logic            ignoreSyncTimeout;
`endif

   trace_frame_capture #(
      .MAXBUSWIDTH(MAXB),
      .DEPTH(DEPTH),
      .SYNC_BITS(SB)
   ) dut (
      .traceClkin(traceClkin),
      .rst(rst),
      .traceDina(traceDina),
      .traceDinb(traceDinb),
      .width(width),
`ifdef SYNC_TIMEOUT_EN
      .ignoreSyncTimeout(ignoreSyncTimeout),
`endif
      .frameReady(frameReady),
      .frameValid(frameValid),
      .frameData(frameData),
      .synced(synced),
      .syncOffset(syncOffset),
      .overflowCount(overflowCount)
   );

   initial traceClkin = 1'b0;
   always #5 traceClkin = ~traceClkin;

   int total = 0;
   int bad   = 0;
   bit mchk  = 1'b1;

   // stimulus bit stream, oldest first
   bit src[$];

   // reference model: history of every bit delivered since reset
   bit           hist[$];
   bit           mSynced;
   int           mOff;
   int           anchor;
   int           mWq;
   logic [15:0]  cur[$];
   logic [127:0] mq[$];
   int           mOvf;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic push_hw(input logic [15:0] v);
      for (int i = 0; i < 16; i++) src.push_back(v[i]);
   endtask

   task automatic push_sync();
      logic [31:0] s;
      s = 32'h7FFF_FFFF;
      for (int i = 0; i < 32; i++) src.push_back(s[i]);
   endtask

   task automatic push_bits(input int n, input bit rnd);
      for (int i = 0; i < n; i++)
         src.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
   endtask

   task automatic model_reset();
      hist.delete();
      cur.delete();
      mq.delete();
      mSynced = 1'b0;
      mOff    = 0;
      anchor  = 0;
      mWq     = 0;
      mOvf    = 0;
   endtask

   task automatic model_step(input logic [15:0] ch, input int nb,
                             input bit rdy);
      bit           pop, push, ones;
      int           L, idx, fnd;
      logic [15:0]  h;
      logic [127:0] f;
      pop  = (mq.size() > 0) && rdy;
      push = 1'b0;
      f    = '0;
      L    = hist.size();
      if (int'(width) != mWq) begin
         mSynced = 1'b0;
         cur.delete();
      end else begin
         fnd = -1;
         for (int o = 0; o < nb && fnd < 0; o++) begin
            idx = L - 1 - o;
            if (idx >= 31 && hist[idx] == 1'b0) begin
               ones = 1'b1;
               for (int k = idx - 31; k < idx; k++)
                  if (!hist[k]) ones = 1'b0;
               if (ones) fnd = o;
            end
         end
         if (fnd >= 0) begin
            mSynced = 1'b1;
            mOff    = fnd;
            anchor  = L - 1 - fnd;
            cur.delete();
         end else if (mSynced && (L - 1 - mOff >= anchor + 16)) begin
            for (int i = 0; i < 16; i++) h[i] = hist[anchor + 1 + i];
            anchor += 16;
            if (h != 16'h7FFF) begin
               cur.push_back({h[7:0], h[15:8]});
               if (cur.size() == 8) begin
                  for (int k = 0; k < 8; k++) f[127 - 16 * k -: 16] = cur[k];
                  push = 1'b1;
                  cur.delete();
               end
            end
         end
      end
      mWq = int'(width);
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < DEPTH) mq.push_back(f);
         else if (mOvf < 65535) mOvf++;
      end
      for (int i = 0; i < nb; i++) hist.push_back(ch[i]);
   endtask

   task automatic check_model();
      chk("m_valid", frameValid, mq.size() > 0);
      chk("m_data", frameData, (mq.size() > 0) ? mq[0] : 128'h0);
      chk("m_synced", synced, mSynced);
      chk("m_offset", syncOffset, mOff);
      chk("m_overflow", overflowCount, mOvf);
   endtask

   task automatic tick(input bit rdy);
      int          nb, wb;
      logic [15:0] ch;
      logic [7:0]  a, b;
      nb = 2 << width;
      wb = nb / 2;
      ch = '0;
      for (int i = 0; i < nb; i++) begin
         if (src.size() == 0) push_hw(16'h7FFF);
         ch[i] = src.pop_front();
      end
      a = 8'($urandom);
      b = 8'($urandom);
      for (int j = 0; j < wb; j++) begin
         a[j] = ch[j];
         b[j] = ch[wb + j];
      end
      traceDina  = a;
      traceDinb  = b;
      frameReady = rdy;
      model_step(ch, nb, rdy);
      @(posedge traceClkin);
      #1;
      if (mchk) check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_valid", frameValid, 0);
      chk("rst_data", frameData, 0);
      chk("rst_synced", synced, 0);
      chk("rst_offset", syncOffset, 0);
      chk("rst_overflow", overflowCount, 0);
      src.delete();
      model_reset();
      @(posedge traceClkin);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_frame(input string nm, input int budget);
      int c;
      c = 0;
      while (!frameValid && c < budget) begin
         tick(1'b0);
         c++;
      end
      chk(nm, frameValid, 1);
   endtask

   typedef struct {
      logic [1:0]         w;
      int                 npre;
      int                 nhw;
      logic [11:0][15:0]  hw;
      logic [127:0]       expFrame;
      logic [3:0]         expOff;
   } vec_t;

   vec_t         tbl[5];
   logic [127:0] ef;

   initial begin
      rst        = 1'b1;
      traceDina  = '0;
      traceDinb  = '0;
      width      = 2'd0;
      frameReady = 1'b0;
`ifdef SYNC_TIMEOUT_EN
      ignoreSyncTimeout = 1'b1;
`endif
      model_reset();

      tbl[0].w = 2'd2; tbl[0].npre = 0;  tbl[0].nhw = 8; tbl[0].hw = '0;
      tbl[0].expOff = 4'd0;
      tbl[0].expFrame = 128'h0201_0403_0605_0807_0A09_0C0B_0E0D_100F;
      for (int i = 0; i < 8; i++)
         tbl[0].hw[i] = 16'(16'h0102 + 16'h0202 * i);
      tbl[1].w = 2'd0; tbl[1].npre = 1;  tbl[1].nhw = 8; tbl[1].hw = '0;
      tbl[1].expOff = 4'd1;
      tbl[1].expFrame = {8{16'hA5A5}};
      for (int i = 0; i < 8; i++) tbl[1].hw[i] = 16'hA5A5;
      tbl[2].w = 2'd1; tbl[2].npre = 1;  tbl[2].nhw = 8; tbl[2].hw = '0;
      tbl[2].expOff = 4'd3;
      tbl[2].expFrame = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      for (int i = 0; i < 8; i++) tbl[2].hw[i] = 16'(16'h1111 * (i + 1));
      tbl[3].w = 2'd3; tbl[3].npre = 11; tbl[3].nhw = 8; tbl[3].hw = '0;
      tbl[3].expOff = 4'd5;
      tbl[3].expFrame = 128'hEFBE_FECA_0100_0080_3412_7856_BC9A_F0DE;
      tbl[3].hw[0] = 16'hBEEF; tbl[3].hw[1] = 16'hCAFE;
      tbl[3].hw[2] = 16'h0001; tbl[3].hw[3] = 16'h8000;
      tbl[3].hw[4] = 16'h1234; tbl[3].hw[5] = 16'h5678;
      tbl[3].hw[6] = 16'h9ABC; tbl[3].hw[7] = 16'hDEF0;
      tbl[4].w = 2'd3; tbl[4].npre = 0;  tbl[4].nhw = 12;
      tbl[4].expOff = 4'd0;
      tbl[4].expFrame = 128'h0201_0403_0605_0807_0A09_0C0B_0E0D_100F;
      tbl[4].hw = {16'h0F10, 16'h0D0E, 16'h7FFF, 16'h0B0C,
                   16'h090A, 16'h0708, 16'h7FFF, 16'h0506,
                   16'h0304, 16'h7FFF, 16'h0102, 16'h7FFF};

      for (int t = 0; t < 5; t++) begin
         do_reset();
         width = tbl[t].w;
         push_bits(tbl[t].npre, 1'b0);
         push_sync();
         for (int i = 0; i < tbl[t].nhw; i++) push_hw(tbl[t].hw[i]);
         wait_frame($sformatf("tbl%0d_valid", t), 300);
         chk($sformatf("tbl%0d_data", t), frameData, tbl[t].expFrame);
         chk($sformatf("tbl%0d_offset", t), syncOffset, tbl[t].expOff);
         chk($sformatf("tbl%0d_synced", t), synced, 1);
         tick(1'b1);
         for (int i = 0; i < 40; i++) tick(1'b0);
         chk($sformatf("tbl%0d_one_frame", t), frameValid, 0);
      end

      // overflow: six frames into a four-deep FIFO, then drain in order
      do_reset();
      width = 2'd3;
      push_sync();
      for (int f = 1; f <= 6; f++)
         for (int i = 0; i < 8; i++) push_hw({8'(f), 8'(i)});
      for (int i = 0; i < 80; i++) tick(1'b0);
      chk("ovf_count", overflowCount, 2);
      for (int f = 1; f <= 4; f++) begin
         for (int k = 0; k < 8; k++) ef[127 - 16 * k -: 16] = {8'(k), 8'(f)};
         chk($sformatf("ovf_pop%0d_valid", f), frameValid, 1);
         chk($sformatf("ovf_pop%0d_data", f), frameData, ef);
         tick(1'b1);
      end
      chk("ovf_drained", frameValid, 0);

      // resync after five halfwords discards them
      do_reset();
      width = 2'd1;
      push_sync();
      for (int i = 1; i <= 5; i++) push_hw(16'(16'h1000 + i));
      push_sync();
      for (int i = 0; i < 8; i++) push_hw(16'(16'h2000 + i));
      wait_frame("resync_valid", 200);
      for (int k = 0; k < 8; k++) ef[127 - 16 * k -: 16] = {8'(k), 8'h20};
      chk("resync_data", frameData, ef);
      tick(1'b1);
      for (int i = 0; i < 40; i++) tick(1'b0);
      chk("resync_one_frame", frameValid, 0);

      // width change mid-frame drops sync until the next sync word
      do_reset();
      width = 2'd1;
      push_sync();
      for (int i = 0; i < 13; i++) push_hw(16'(16'h3000 + i));
      for (int i = 0; i < 21; i++) tick(1'b0);
      chk("wchg_synced_before", synced, 1);
      width = 2'd2;
      tick(1'b0);
      chk("wchg_synced_after", synced, 0);
      src.delete();
      for (int i = 0; i < 60; i++) tick(1'b0);
      chk("wchg_no_frame", frameValid, 0);
      push_sync();
      for (int i = 0; i < 8; i++) push_hw(16'(16'h4000 + i));
      wait_frame("wchg_resync_valid", 200);
      for (int k = 0; k < 8; k++) ef[127 - 16 * k -: 16] = {8'(k), 8'h40};
      chk("wchg_resync_data", frameData, ef);

`ifdef SYNC_TIMEOUT_EN
      begin
         int c;
         mchk = 1'b0;
         ignoreSyncTimeout = 1'b0;
         do_reset();
         width = 2'd3;
         push_sync();
         c = 0;
         while (!synced && c < 10) begin tick(1'b0); c++; end
         chk("to_synced", synced, 1);
         for (int i = 0; i < 15; i++) tick(1'b0);
         chk("to_still_synced", synced, 1);
         tick(1'b0);
         chk("to_dropped", synced, 0);
         for (int i = 0; i < 8; i++) push_hw(16'(16'h5000 + i));
         for (int i = 0; i < 20; i++) tick(1'b0);
         chk("to_ignored", frameValid, 0);
         ignoreSyncTimeout = 1'b1;
         do_reset();
         push_sync();
         for (int i = 0; i < 40; i++) tick(1'b0);
         chk("to_suppressed", synced, 1);
         mchk = 1'b1;
      end
`endif

      // random streams with width changes, pass halfwords and resets
      do_reset();
      for (int s = 0; s < 60; s++) begin
         int n, bias, c;
         if ($urandom_range(0, 4) == 0) do_reset();
         width = 2'($urandom_range(0, 3));
         push_bits($urandom_range(0, 20), 1'b1);
         push_sync();
         n = $urandom_range(4, 40);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) push_hw(16'h7FFF);
            else push_hw(16'($urandom));
            if ($urandom_range(0, 15) == 0) push_sync();
         end
         bias = $urandom_range(0, 3);
         c = 0;
         while (src.size() > 0 && c < 2000) begin
            tick($urandom_range(0, 3) < bias);
            c++;
            if ($urandom_range(0, 300) == 0) do_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_frame_capture.md
Name: trace_frame_capture

Overview:
- Parametrised TPIU frame capture front end on the traceClkin domain.
- Accepts DDR trace data at 1, 2, 4 or 8 bits per edge and detects full sync (0x7FFF_FFFF) at any bit offset within a clock's input chunk.
- Assembles 16-bit halfwords, dropping 0x7FFF pass halfwords, into 128-bit TPIU frames.
- Queues frames in a DEPTH-entry FIFO with a valid/ready handshake and overflow accounting. The packet processor consumes frames from this FIFO.

Parameters:
- MAXBUSWIDTH, 8, maximum trace pins supported; legal values 1, 2, 4, 8.
- DEPTH, 4, frame FIFO entries; power of two, minimum 2.
- SYNC_BITS, 27, width of the sync timeout counter (used only with the optional feature).

Ports:
- traceClkin  in  1  trace clock; all logic is clocked on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- traceDina  in  MAXBUSWIDTH  data sampled on the rising edge (LSBs of each chunk).
- traceDinb  in  MAXBUSWIDTH  data sampled on the falling edge (MSBs of each chunk).
- width  in  2  bus width W: 0=1, 1=2, 2=4, 3=8 bits; must not exceed MAXBUSWIDTH.
- frameReady  in  1  consumer accepts the head frame.
- frameValid  out  1  FIFO non-empty.
- frameData  out  128  head frame; first halfword in [127:112].
- synced  out  1  sync held.
- syncOffset  out  4  bit offset of the current sync alignment.
- overflowCount  out  16  frames dropped because the FIFO was full; saturates at 0xFFFF.

Behaviour:
- Chunk: each clock shifts the 2W bits {traceDinb[W-1:0],traceDina[W-1:0]} into the top of a shift register of 32+2*MAXBUSWIDTH bits (TOP = MSB).
- Sync detection: each clock, test offsets o = 0..2W-1 for sr[TOP-o -: 32] == 32'h7FFF_FFFF; the lowest matching o wins.
- On sync:
  - synced <= 1, syncOffset <= o.
  - Halfword counter <= C-1, where C = 16/(2W), i.e. 8, 4, 2, 1 for W = 1, 2, 4, 8.
  - Slot index <= 0; any partial frame is discarded.
  - Sync takes priority over a halfword completing on the same clock.
- Halfword capture: when synced and the counter is 0, take hw = sr[TOP-syncOffset -: 16] and reload the counter to C-1; otherwise decrement the counter.
  - hw == 16'h7FFF: discarded; slot unchanged.
  - Any other value: stored byte-swapped as {hw[7:0],hw[15:8]} at the current slot, and slot increments.
  - Slot 0 maps to [127:112]; slot 7 maps to [15:0].
- Frame completion: on storing slot 7, the assembled frame is pushed and the slot wraps to 0.
  - frameValid and frameData reflect the new frame on the following clock (first-word fall-through, one-cycle latency).
- Width change: any change of width from its registered value clears synced, zeroes the slot and discards the partial frame. No halfwords are captured until a new sync arrives.
- FIFO:
  - Pop occurs when frameValid && frameReady.
  - A push while full with no pop in the same cycle drops the new frame and increments overflowCount (saturating).
  - A push and pop in the same cycle while full are both accepted.
  - A push and pop in the same cycle while empty is a push only (frameValid was 0).
  - frameData is stable while frameValid && !frameReady.
- Reset, asynchronous and taking effect at any point mid-frame:
  - All of frameValid, synced, syncOffset, overflowCount, FIFO pointers, slot and counter go to 0.
  - frameData reads 0.
  - The shift register clears to 0, so no false sync can occur from stale data.

Optional Feature:
- Macro SYNC_TIMEOUT_EN.
- Defined:
  - A SYNC_BITS-bit counter loads all-ones on each sync and decrements every clock while nonzero.
  - When it reaches 0, synced <= 0; the partial frame is discarded and capture stops until the next sync.
  - An extra input ignoreSyncTimeout (1 bit) suppresses the timeout while high.
- Not defined: sync, once gained, is held until reset, a width change or a new sync. The ignoreSyncTimeout port does not exist.

Test Plan:
- W=4: 0x7FFF_FFFF aligned at offset 0, then halfwords 0x0102..0x0F10 → after 16 clocks frameValid=1, frameData=0x0201_0403_..._100F, syncOffset=0.
- W=1: sync shifted by one bit (offset 1), then 8 halfwords 0xA5A5 → frameData=128'hA5A5…A5A5, syncOffset=1, capture every 8 clocks.
- W=8: sync, then halfwords interleaved with 0x7FFF → the 0x7FFF halfwords are absent and exactly one frame is produced from 8 non-pass halfwords.
- DEPTH=4, frameReady=0, 6 frames sent → FIFO holds frames 1-4, overflowCount=2. Then frameReady=1 → frames 1-4 are popped in order.
- A new sync after 5 halfwords, then 8 halfwords → exactly one frame containing only the post-sync halfwords. A width change mid-frame → synced=0 and no frame until re-sync.
- SYNC_TIMEOUT_EN with SYNC_BITS=4: sync, 16 idle clocks → synced=0, subsequent halfwords ignored. The same run with ignoreSyncTimeout=1 → synced stays 1.
